// File: rtl/fetch_queue_stage.sv
// Decoupled instruction-fetch stage: in-order outstanding requests on the SRAM-like bus, tag queue, FIFO toward ID.
// Define FETCH_BYPASS_EN to forward a return straight to ID when the FIFO is empty (zero-latency path).
module fetch_queue_stage #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_OUTST  = 2,
    parameter logic [31:0] RESET_PC   = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        exc_fetch_i,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_exc_adef_o,
    output logic        if_exc_mmu_o,
    output logic [2:0]  outst_cnt_o
);
    localparam int          PW     = $clog2(FIFO_DEPTH);
    localparam int          CW     = PW + 1;
    localparam logic [7:0]  DEPTH8 = 8'(FIFO_DEPTH);
    localparam logic [2:0]  MAX3   = 3'(MAX_OUTST);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          halted_q, halted_d;
    logic [2:0]    outst_cnt_q, outst_cnt_d;
    logic [2:0]    discard_cnt_q, discard_cnt_d;

    // tag queue entries: pc plus fault flags {adef, mmu}; head is always index 0
    logic [31:0]   tq_pc_q  [MAX_OUTST];
    logic [31:0]   tq_pc_d  [MAX_OUTST];
    logic [1:0]    tq_flt_q [MAX_OUTST];
    logic [1:0]    tq_flt_d [MAX_OUTST];
    logic [2:0]    tq_cnt_q, tq_cnt_d;

    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
    logic [31:0]   fifo_inst_q [FIFO_DEPTH];
    logic [31:0]   fifo_inst_d [FIFO_DEPTH];
    logic [1:0]    fifo_flt_q  [FIFO_DEPTH];
    logic [1:0]    fifo_flt_d  [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic          adef, can_issue, accept, fake, dok, ret_real, head_fault;
    logic          tq_pop, tq_push, fifo_valid, fifo_push, fifo_pop;
    logic          byp_valid, byp_take;
    logic [2:0]    inflight;
    logic [7:0]    credit_used;

    assign adef        = fetch_pc_q[1:0] != 2'b00;
    assign inflight    = outst_cnt_q - discard_cnt_q;
    assign credit_used = {5'b0, inflight} + {{(8-CW){1'b0}}, fifo_cnt_q};
    assign can_issue   = resetn & !halted_q & !fetch_stall & !redirect
                         & (outst_cnt_q < MAX3) & (credit_used < DEPTH8);
    assign inst_req    = can_issue & !adef & !exc_fetch_i;
    assign inst_addr   = fetch_pc_q;
    assign accept      = inst_req & inst_addr_ok;
    assign fake        = can_issue & (adef | exc_fetch_i);

    // a return with nothing outstanding is a protocol error and is ignored
    assign dok         = inst_data_ok & (outst_cnt_q != 3'd0);
    assign ret_real    = dok & (discard_cnt_q == 3'd0);
    assign head_fault  = (tq_cnt_q != 3'd0) & (tq_flt_q[0] != 2'b00);
    assign tq_pop      = !redirect & (head_fault | ret_real);
    assign tq_push     = accept | fake;
    assign fifo_valid  = fifo_cnt_q != '0;

`ifdef FETCH_BYPASS_EN
    assign byp_valid = !fifo_valid & ret_real & !head_fault & !redirect;
    assign byp_take  = byp_valid & id_allowin;
`else
    assign byp_valid = 1'b0;
    assign byp_take  = 1'b0;
`endif

    assign fifo_push = tq_pop & !byp_take;
    assign fifo_pop  = fifo_valid & id_allowin;

    always_comb begin
        if_to_id_valid = fifo_valid | byp_valid;
        if_pc_o        = 32'h0;
        if_inst_o      = 32'h0;
        if_exc_adef_o  = 1'b0;
        if_exc_mmu_o   = 1'b0;
        if (fifo_valid) begin
            if_pc_o       = fifo_pc_q[rd_ptr_q];
            if_inst_o     = fifo_inst_q[rd_ptr_q];
            if_exc_adef_o = fifo_flt_q[rd_ptr_q][1];
            if_exc_mmu_o  = fifo_flt_q[rd_ptr_q][0];
        end else if (byp_valid) begin
            if_pc_o   = tq_pc_q[0];
            if_inst_o = inst_rdata;
        end
    end

    assign outst_cnt_o = outst_cnt_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        halted_d      = halted_q;
        outst_cnt_d   = outst_cnt_q + {2'b0, accept} - {2'b0, dok};
        discard_cnt_d = discard_cnt_q;
        tq_pc_d       = tq_pc_q;
        tq_flt_d      = tq_flt_q;
        tq_cnt_d      = tq_cnt_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_inst_d   = fifo_inst_q;
        fifo_flt_d    = fifo_flt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (accept)
            fetch_pc_d = fetch_pc_q + 32'd4;
        if (fake)
            halted_d = 1'b1;
        if (dok && discard_cnt_q != 3'd0)
            discard_cnt_d = discard_cnt_q - 3'd1;

        if (tq_pop) begin
            for (int i = 0; i < MAX_OUTST - 1; i++) begin
                tq_pc_d[i]  = tq_pc_q[i+1];
                tq_flt_d[i] = tq_flt_q[i+1];
            end
            tq_cnt_d = tq_cnt_q - 3'd1;
        end
        // misalignment is detected before translation, so it wins over an MMU fault
        for (int i = 0; i < MAX_OUTST; i++) begin
            if (tq_push && 3'(i) == tq_cnt_d) begin
                tq_pc_d[i]  = fetch_pc_q;
                tq_flt_d[i] = {adef, exc_fetch_i & !adef};
            end
        end
        if (tq_push)
            tq_cnt_d = tq_cnt_d + 3'd1;

        if (fifo_push) begin
            fifo_pc_d[wr_ptr_q]   = tq_pc_q[0];
            fifo_inst_d[wr_ptr_q] = ret_real ? inst_rdata : 32'h0;
            fifo_flt_d[wr_ptr_q]  = tq_flt_q[0];
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (fifo_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        fifo_cnt_d = fifo_cnt_q + {{(CW-1){1'b0}}, fifo_push} - {{(CW-1){1'b0}}, fifo_pop};

        // redirect overrides everything; stale returns are dropped by count
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            halted_d      = 1'b0;
            discard_cnt_d = outst_cnt_q - {2'b0, dok};
            tq_cnt_d      = 3'd0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            fifo_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q    <= RESET_PC;
            halted_q      <= 1'b0;
            outst_cnt_q   <= 3'd0;
            discard_cnt_q <= 3'd0;
            tq_cnt_q      <= 3'd0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                tq_pc_q[i]  <= 32'h0;
                tq_flt_q[i] <= 2'b00;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= 32'h0;
                fifo_inst_q[i] <= 32'h0;
                fifo_flt_q[i]  <= 2'b00;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            halted_q      <= halted_d;
            outst_cnt_q   <= outst_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            tq_cnt_q      <= tq_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tq_pc_q       <= tq_pc_d;
            tq_flt_q      <= tq_flt_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_inst_q   <= fifo_inst_d;
            fifo_flt_q    <= fifo_flt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(inst_data_ok && outst_cnt_q == 3'd0));
            assert (outst_cnt_q <= MAX3);
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage (default build, FIFO_DEPTH=4, MAX_OUTST=2).
module tb_fetch_queue_stage;
    logic        clk = 1'b0;
    logic        resetn, redirect, fetch_stall, inst_addr_ok, inst_data_ok, exc_fetch_i, id_allowin;
    logic [31:0] redirect_pc, inst_rdata, inst_addr, if_pc_o, if_inst_o;
    logic        inst_req, if_to_id_valid, if_exc_adef_o, if_exc_mmu_o;
    logic [2:0]  outst_cnt_o;
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] RST = 32'h1c000000;
    localparam logic [31:0] R0  = 32'h1c000100;
    localparam logic [31:0] B0  = 32'h1c000200;

    always #5 clk = ~clk;

    fetch_queue_stage dut (
        .clk(clk), .resetn(resetn), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_stall(fetch_stall), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .exc_fetch_i(exc_fetch_i), .id_allowin(id_allowin), .if_to_id_valid(if_to_id_valid),
        .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_exc_adef_o(if_exc_adef_o),
        .if_exc_mmu_o(if_exc_mmu_o), .outst_cnt_o(outst_cnt_o)
    );

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'h5a5a_0000;
    endfunction

    function automatic logic [31:0] a(input int n);
        return RST + 32'(4 * n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; fetch_stall = 1'b0;
        inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        exc_fetch_i = 1'b0; id_allowin = 1'b1;
        tick(); tick();
        chk("rst_valid", if_to_id_valid, 0);
        chk("rst_req", inst_req, 0);
        chk("rst_pc", if_pc_o, 0);
        chk("rst_inst", if_inst_o, 0);
        chk("rst_outst", outst_cnt_o, 0);
        chk("rst_flags", {if_exc_adef_o, if_exc_mmu_o}, 0);

        // streaming: two requests back to back, then one issue plus one return per cycle
        resetn = 1'b1; settle();
        chk("s1_req0", inst_req, 1);
        chk("s1_addr0", inst_addr, a(0));
        tick();
        chk("s1_outst1", outst_cnt_o, 1);
        settle();
        chk("s1_req1", inst_req, 1);
        chk("s1_addr1", inst_addr, a(1));
        tick();
        chk("s1_outst2", outst_cnt_o, 2);
        inst_data_ok = 1'b1; inst_rdata = ins(a(0)); settle();
        chk("s1_req_max", inst_req, 0);
        tick();
        chk("s1_valid", if_to_id_valid, 1);
        chk("s1_pc0", if_pc_o, a(0));
        chk("s1_inst0", if_inst_o, ins(a(0)));
        chk("s1_outst_after", outst_cnt_o, 1);
        for (int k = 3; k <= 6; k++) begin
            inst_rdata = ins(a(k - 2)); settle();
            chk("s1_req", inst_req, 1);
            chk("s1_addr", inst_addr, a(k - 1));
            tick();
            chk("s1_head_pc", if_pc_o, a(k - 2));
            chk("s1_head_inst", if_inst_o, ins(a(k - 2)));
        end
        fetch_stall = 1'b1; inst_rdata = ins(a(5)); settle();
        chk("s1_stall_req", inst_req, 0);
        tick();
        chk("s1_last_pc", if_pc_o, a(5));
        inst_data_ok = 1'b0; tick();
        chk("s1_drained_valid", if_to_id_valid, 0);
        chk("s1_drained_outst", outst_cnt_o, 0);

        // backpressure: exactly FIFO_DEPTH instructions accepted
        fetch_stall = 1'b0; id_allowin = 1'b0; settle();
        chk("s2_req6", inst_req, 1);
        chk("s2_addr6", inst_addr, a(6));
        tick();
        for (int j = 0; j < 3; j++) begin
            inst_data_ok = 1'b1; inst_rdata = ins(a(6 + j)); settle();
            chk("s2_req", inst_req, 1);
            chk("s2_addr", inst_addr, a(7 + j));
            tick();
        end
        inst_rdata = ins(a(9)); settle();
        chk("s2_full_req", inst_req, 0);
        tick();
        inst_data_ok = 1'b0; settle();
        chk("s2_held_req", inst_req, 0);
        chk("s2_held_valid", if_to_id_valid, 1);
        chk("s2_held_pc", if_pc_o, a(6));
        chk("s2_held_inst", if_inst_o, ins(a(6)));
        tick();
        id_allowin = 1'b1; settle();
        chk("s2_pop_cycle_req", inst_req, 0);
        tick();
        chk("s2_resume_req", inst_req, 1);
        chk("s2_resume_addr", inst_addr, a(10));
        chk("s2_resume_pc", if_pc_o, a(7));
        tick();

        // redirect with two outstanding: both stale returns dropped
        settle();
        chk("s3_req11", inst_req, 1);
        chk("s3_addr11", inst_addr, a(11));
        tick();
        chk("s3_outst2", outst_cnt_o, 2);
        redirect = 1'b1; redirect_pc = R0; settle();
        chk("s3_redir_req", inst_req, 0);
        tick();
        chk("s3_redir_valid", if_to_id_valid, 0);
        chk("s3_redir_outst", outst_cnt_o, 2);
        redirect = 1'b0; inst_data_ok = 1'b1; inst_rdata = ins(a(10)); settle();
        chk("s3_max_req", inst_req, 0);
        tick();
        chk("s3_drop1_valid", if_to_id_valid, 0);
        chk("s3_drop1_outst", outst_cnt_o, 1);
        inst_rdata = ins(a(11)); settle();
        chk("s3_new_req", inst_req, 1);
        chk("s3_new_addr", inst_addr, R0);
        tick();
        chk("s3_drop2_valid", if_to_id_valid, 0);
        chk("s3_drop2_outst", outst_cnt_o, 1);
        inst_rdata = ins(R0); settle();
        chk("s3_next_addr", inst_addr, R0 + 32'd4);
        tick();
        chk("s3_first_valid", if_to_id_valid, 1);
        chk("s3_first_pc", if_pc_o, R0);
        chk("s3_first_inst", if_inst_o, ins(R0));

        // redirect coincident with a return while two are outstanding
        inst_data_ok = 1'b0; settle();
        chk("s4_addr", inst_addr, R0 + 32'd8);
        tick();
        chk("s4_outst2", outst_cnt_o, 2);
        redirect = 1'b1; redirect_pc = B0; inst_data_ok = 1'b1; inst_rdata = ins(R0 + 32'd4);
        tick();
        chk("s4_redir_outst", outst_cnt_o, 1);
        chk("s4_redir_valid", if_to_id_valid, 0);
        redirect = 1'b0; inst_rdata = ins(R0 + 32'd8); settle();
        chk("s4_new_req", inst_req, 1);
        chk("s4_new_addr", inst_addr, B0);
        tick();
        chk("s4_stale_valid", if_to_id_valid, 0);
        chk("s4_stale_outst", outst_cnt_o, 1);
        inst_rdata = ins(B0); tick();
        chk("s4_first_pc", if_pc_o, B0);
        chk("s4_first_inst", if_inst_o, ins(B0));
        fetch_stall = 1'b1; inst_rdata = ins(B0 + 32'd4); tick();
        chk("s4_second_pc", if_pc_o, B0 + 32'd4);
        inst_data_ok = 1'b0; tick();
        chk("s4_drained_valid", if_to_id_valid, 0);
        chk("s4_drained_outst", outst_cnt_o, 0);

        // MMU fault: tagged entry, no bus access, halt until redirect
        redirect = 1'b1; redirect_pc = 32'h1c000008; tick();
        redirect = 1'b0; fetch_stall = 1'b0; exc_fetch_i = 1'b1; settle();
        chk("s5_fault_req", inst_req, 0);
        tick();
        exc_fetch_i = 1'b0; settle();
        chk("s5_halted_req", inst_req, 0);
        chk("s5_pending_valid", if_to_id_valid, 0);
        tick();
        chk("s5_valid", if_to_id_valid, 1);
        chk("s5_pc", if_pc_o, 32'h1c000008);
        chk("s5_mmu", if_exc_mmu_o, 1);
        chk("s5_adef", if_exc_adef_o, 0);
        chk("s5_inst", if_inst_o, 0);
        chk("s5_outst", outst_cnt_o, 0);
        tick();
        chk("s5_popped_valid", if_to_id_valid, 0);
        chk("s5_still_halted", inst_req, 0);
        tick();
        chk("s5_still_halted2", inst_req, 0);
        redirect = 1'b1; redirect_pc = 32'h1c008000; tick();
        redirect = 1'b0; inst_addr_ok = 1'b0; settle();
        chk("s5_resume_req", inst_req, 1);
        chk("s5_resume_addr", inst_addr, 32'h1c008000);

        // misaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h1c000002; inst_addr_ok = 1'b1; tick();
        redirect = 1'b0; settle();
        chk("s6_adef_req", inst_req, 0);
        tick(); tick();
        chk("s6_valid", if_to_id_valid, 1);
        chk("s6_pc", if_pc_o, 32'h1c000002);
        chk("s6_adef", if_exc_adef_o, 1);
        chk("s6_mmu", if_exc_mmu_o, 0);
        chk("s6_inst", if_inst_o, 0);

        // reset while a request is outstanding
        redirect = 1'b1; redirect_pc = 32'h1c000040; tick();
        redirect = 1'b0; settle();
        chk("s7_req", inst_req, 1);
        tick();
        chk("s7_outst", outst_cnt_o, 1);
        resetn = 1'b0; tick();
        chk("s7_rst_outst", outst_cnt_o, 0);
        chk("s7_rst_valid", if_to_id_valid, 0);
        resetn = 1'b1; fetch_stall = 1'b0; inst_addr_ok = 1'b0; settle();
        chk("s7_rst_addr", inst_addr, RST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Decoupled, parametrised instruction-fetch stage for the LoongArch pipeline.
- Issues multiple outstanding in-order requests on the SRAM-like inst bus (addr_ok/data_ok).
- Buffers returned instructions in a FIFO toward ID.
- On redirect (branch/exception/ertn/refetch, resolved upstream into a single redirect), drops stale returns by count. MMU fetch faults and misaligned PCs pass down the pipe as tagged entries that make no bus access.

Parameters:
- FIFO_DEPTH, 4, instruction FIFO entries; power of 2, at least 2.
- MAX_OUTST, 2, maximum issued-but-unreturned bus requests; 1 to 4.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- redirect  in  1  flush fetch and restart at redirect_pc
- redirect_pc  in  32  new fetch PC
- fetch_stall  in  1  suppress new requests (e.g. branch unresolved)
- inst_req  out  1  bus request
- inst_addr  out  32  request address (= fetch_pc)
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  data return, in order
- inst_rdata  in  32  returned instruction
- exc_fetch_i  in  1  MMU fault for inst_addr this cycle (PIF/PPI/TLBR)
- id_allowin  in  1  ID accepts
- if_to_id_valid  out  1  FIFO head valid
- if_pc_o  out  32  head PC
- if_inst_o  out  32  head instruction (32'h0 for fault entries)
- if_exc_adef_o  out  1  head is address-misaligned fault
- if_exc_mmu_o  out  1  head is MMU fault
- outst_cnt_o  out  3  live outstanding count (debug)

Behaviour:
- Reset (resetn=0 at posedge):
  - fetch_pc=RESET_PC
  - FIFO empty
  - outst_cnt=0, discard_cnt=0, halted=0
  - Outputs: if_to_id_valid=0, inst_req=0, if_pc_o/if_inst_o=0, flags=0.
- Credit and request:
  - can_issue = !halted & !fetch_stall & !redirect & outst_cnt<MAX_OUTST & (outst_cnt-discard_cnt+fifo_count)<FIFO_DEPTH.
  - adef = fetch_pc[1:0]!=0.
  - inst_req = can_issue & !adef & !exc_fetch_i.
- Accept: on inst_req & inst_addr_ok:
  - push {fetch_pc} into in-flight tag queue (depth MAX_OUTST)
  - outst_cnt+1
  - fetch_pc += 4 (32-bit wrap).
- Fake completion: if can_issue & (adef|exc_fetch_i):
  - no bus request
  - push fault entry into tag queue with flag set
  - halted <= 1; no further issue until redirect.
  - Fault entry retires into the FIFO the first cycle it is tag-queue head, without data_ok.
- Return: on inst_data_ok:
  - if discard_cnt>0: discard_cnt-1, outst_cnt-1, tag not popped (stale tags already cleared), data dropped.
  - else: pop tag head, write {pc,rdata} into FIFO, outst_cnt-1.
  - Visible on outputs next cycle (1-cycle latency).
- Output:
  - FIFO head drives the if_* outputs.
  - Pop when if_to_id_valid & id_allowin.
  - Simultaneous push and pop is allowed when full-minus-one or empty-plus-one.
- Redirect (highest priority):
  - fetch_pc <= redirect_pc; FIFO and tag queue cleared; halted <= 0.
  - discard_cnt <= real outstanding requests, minus 1 if inst_data_ok in the same cycle. That same-cycle data is dropped.
  - A fake completion or pop in the same cycle is ignored.
  - Issue resumes the next cycle, even while discard_cnt>0; new returns follow the stale ones in order.
- Invariants:
  - outst_cnt never exceeds MAX_OUTST.
  - FIFO never overflows; credit guarantees a slot for every non-discarded return.
  - data_ok with outst_cnt=0 is a protocol error; assertion only.
- Reset mid-operation: all state cleared. Returns arriving afterward are ignored because outst_cnt=0.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and a non-discarded, non-fault data_ok arrives, {pc,rdata} drive the outputs combinationally in the same cycle.
  - If id_allowin=1 the entry is consumed and never written to the FIFO; otherwise it is written as normal.
  - Latency 0.
- Undefined: 1-cycle latency through the FIFO only.

Test Plan:
- Reset release, id_allowin=1, addr_ok/data_ok one cycle after each req -> requests at 0x1c000000, 0x1c000004, ...; with MAX_OUTST=2 two requests are in flight back-to-back; if_pc_o follows the same sequence.
- id_allowin=0, FIFO_DEPTH=4 -> exactly 4 instructions accepted, then inst_req=0. Raising id_allowin resumes issue one cycle after the first pop.
- Two requests outstanding, redirect to 0x1c000100 -> next two data_ok dropped (discard_cnt 2->1->0); first if_pc_o=0x1c000100 with its correct instruction.
- Redirect in the same cycle as data_ok with outst_cnt=2 -> discard_cnt=1; no stale PC ever appears at the output.
- exc_fetch_i=1 at fetch_pc 0x1c000008 -> no inst_req; entry with if_exc_mmu_o=1, if_inst_o=0; fetch halted until a redirect to 0x1c008000.
- Redirect to 0x1c000002 -> no bus request; if_exc_adef_o=1 with if_pc_o=0x1c000002.
